fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage of the RV32i pipeline. Holds the fetch PC, issues single-outstanding requests to instruction memory, and registers the returned instruction into the IF/ID pipeline register for decode. The next-PC choice between sequential PC+4 and the execute-stage redirect target is made by a 2:1 PC-select mux. This block owns the PC register behind that mux and the IF/ID register that consumes its output. Stall, flush and stale-response discard are handled internally.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset.

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
PC_SEL  input  1  redirect from execute (taken branch/jump); 1 selects PC_TARGET
PC_TARGET  input  32  redirect address from execute
STALL  input  1  hazard unit: decode cannot accept; IF/ID holds
IMEM_REQ  output  1  fetch request valid
IMEM_ADDR  output  32  fetch address (word aligned)
IMEM_READY  input  1  memory accepts request this cycle (handshake when REQ&READY)
IMEM_RVALID  input  1  response valid; at most one per accepted request, at least 1 cycle after accept
IMEM_RDATA  input  32  instruction word, valid with IMEM_RVALID
INSTR_D  output  32  IF/ID instruction
PC_D  output  32  IF/ID PC of INSTR_D
PC_PLUS4_D  output  32  IF/ID PC_D+4
VALID_D  output  1  IF/ID entry valid (0 = bubble)

Behaviour:
- Reset (RST=1 at edge): PC_F=RESET_PC, state=REQ, hold buffer empty, INSTR_D=32'h0000_0013 (NOP), PC_D=0, PC_PLUS4_D=0, VALID_D=0. IMEM_REQ forced 0 while RST=1. Reset mid-request abandons the transaction; the memory is reset on the same RST.
- IMEM_ADDR=PC_F at all times. Redirect target bits [1:0] are forced to 00. PC+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Only one request outstanding.
- States:
  - REQ: IMEM_REQ=1. On READY go to WAIT.
  - WAIT: IMEM_REQ=0. On RVALID with STALL=0: load IF/ID {RDATA, PC_F, PC_F+4, 1}, set PC_F+=4, go to REQ. On RVALID with STALL=1: capture into hold buffer, go to HELD.
  - HELD: IMEM_REQ=0. When STALL=0: move hold buffer into IF/ID (VALID_D=1), set PC_F+=4, go to REQ.
  - DROP: IMEM_REQ=0, waiting for the stale response. On RVALID discard it and go to REQ.
- IF/ID update rule:
  - STALL=1 and no redirect: all D outputs hold.
  - STALL=0 and nothing delivered this cycle: VALID_D<=0 (bubble); INSTR_D, PC_D and PC_PLUS4_D hold.
- Redirect (PC_SEL=1) has priority over STALL and over any delivery:
  - Next edge: PC_F<=PC_TARGET&~3 and VALID_D<=0.
  - REQ with READY=1: go to DROP.
  - REQ with READY=0: stay in REQ at the new address.
  - WAIT with RVALID=0: go to DROP.
  - WAIT with RVALID=1: discard the response, go to REQ.
  - HELD: clear hold buffer, go to REQ.
  - DROP: stay in DROP, PC updated.
- Latency: request accepted in cycle n, RVALID in n+1, VALID_D=1 visible in n+2. Peak throughput is 1 instruction per 2 cycles.

Decomposition:
- Shared package (common pkg): NOP_INSTR=32'h0000_0013, default RESET_PC, enum fetch_state_t {REQ, WAIT, HELD, DROP}.
- Sub-module: instantiate the existing mux2_1 for next-PC select (A=PC_F+4, B=PC_TARGET&~3, SEL=PC_SEL).
- PC register, FSM and IF/ID register stay in fetch_unit.

Test Plan:
- Reset, RESET_PC=0x100, READY=1, RVALID one cycle after accept -> IMEM_ADDR sequence 0x100, 0x104, 0x108. VALID_D pulses every 2nd cycle with PC_D 0x100, 0x104, 0x108 and PC_PLUS4_D=PC_D+4.
- STALL=1 for 3 cycles when RVALID arrives with RDATA=0x00500093 -> IF/ID holds its previous entry, no new IMEM_REQ. After STALL drops, INSTR_D=0x00500093, VALID_D=1, next IMEM_ADDR=PC+4.
- PC_SEL=1, PC_TARGET=0x203 while in WAIT -> next cycle VALID_D=0. The next RVALID is discarded (INSTR_D unchanged), then IMEM_ADDR=0x200 is requested.
- PC_SEL=1 together with STALL=1 in HELD -> hold buffer dropped, VALID_D=0, IMEM_REQ at target next cycle.
- PC_F=0xFFFF_FFFC, fetch completes -> PC_PLUS4_D=0x0000_0000 and next IMEM_ADDR=0x0000_0000.
- RST=1 asserted in WAIT with RVALID arriving the same cycle -> all outputs at reset values, response ignored, IMEM_REQ=0 until RST=0, then request at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the RV32i instruction-fetch stage.
package fetch_unit_pkg;

    // Canonical RV32i NOP: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // REQ : request driven, waiting for the memory to accept it
    // WAIT: request accepted, waiting for its response
    // HELD: response captured while decode was stalled
    // DROP: a redirect orphaned the outstanding request; swallow its response
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HELD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/mux2_1.sv
// Generic 2:1 multiplexer; SEL=1 selects B.
module mux2_1 #(
    parameter int W = 32
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         SEL,
    output logic [W-1:0] Y
);

    assign Y = SEL ? B : A;

endmodule

// File: rtl/fetch_unit.sv
// RV32i fetch stage: PC register, single-outstanding imem handshake FSM,
// stall hold buffer, and the IF/ID pipeline register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PC_SEL,
    input  logic [31:0] PC_TARGET,
    input  logic        STALL,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_READY,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] INSTR_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC_PLUS4_D,
    output logic        VALID_D
);

    fetch_state_t r_state;
    logic [31:0]  r_pc_f;
    logic [31:0]  r_hold_instr;
    logic [31:0]  r_instr_d;
    logic [31:0]  r_pc_d;
    logic [31:0]  r_pc_plus4_d;
    logic         r_valid_d;

    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_target_aligned;
    logic [31:0]  w_next_pc;

    // Sequential PC wraps naturally modulo 2^32; redirect targets are word aligned.
    assign w_pc_plus4       = r_pc_f + 32'd4;
    assign w_target_aligned = {PC_TARGET[31:2], 2'b00};

    mux2_1 #(.W(32)) u_pc_mux (
        .A   (w_pc_plus4),
        .B   (w_target_aligned),
        .SEL (PC_SEL),
        .Y   (w_next_pc)
    );

    // Request is only driven from REQ and is suppressed while reset is held.
    assign IMEM_REQ   = (r_state == REQ) && !RST;
    assign IMEM_ADDR  = r_pc_f;
    assign INSTR_D    = r_instr_d;
    assign PC_D       = r_pc_d;
    assign PC_PLUS4_D = r_pc_plus4_d;
    assign VALID_D    = r_valid_d;

    // Fetch FSM, PC register, hold buffer and IF/ID register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: every register here is a small flop, not a memory array, so all get reset.
            r_state      <= REQ;
            r_pc_f       <= RESET_PC;
            r_hold_instr <= NOP_INSTR;
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else begin
            // NOTE: this default bubble is overridden by any later delivery below;
            // with non-blocking assignments the last one in program order wins.
            if (!STALL || PC_SEL) begin
                r_valid_d <= 1'b0;
            end

            if (PC_SEL) begin
                // Redirect outranks stall and any delivery this cycle.
                r_pc_f <= w_next_pc;
                case (r_state)
                    REQ:  r_state <= IMEM_READY ? DROP : REQ;
                    WAIT: r_state <= IMEM_RVALID ? REQ : DROP;
                    HELD: begin
                        r_hold_instr <= NOP_INSTR;
                        r_state      <= REQ;
                    end
                    // A stale response landing now is consumed; otherwise keep waiting.
                    DROP: r_state <= IMEM_RVALID ? REQ : DROP;
                    default: r_state <= REQ;
                endcase
            end else begin
                case (r_state)
                    REQ: begin
                        if (IMEM_READY) begin
                            r_state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (IMEM_RVALID) begin
                            if (!STALL) begin
                                r_instr_d    <= IMEM_RDATA;
                                r_pc_d       <= r_pc_f;
                                r_pc_plus4_d <= w_pc_plus4;
                                r_valid_d    <= 1'b1;
                                r_pc_f       <= w_next_pc;
                                r_state      <= REQ;
                            end else begin
                                r_hold_instr <= IMEM_RDATA;
                                r_state      <= HELD;
                            end
                        end
                    end
                    HELD: begin
                        if (!STALL) begin
                            r_instr_d    <= r_hold_instr;
                            r_pc_d       <= r_pc_f;
                            r_pc_plus4_d <= w_pc_plus4;
                            r_valid_d    <= 1'b1;
                            r_pc_f       <= w_next_pc;
                            r_state      <= REQ;
                        end
                    end
                    DROP: begin
                        if (IMEM_RVALID) begin
                            r_state <= REQ;
                        end
                    end
                    default: r_state <= REQ;
                endcase
            end
        end
    end

endmodule
